// File: rtl/ex_mem_lsu_pkg.sv
// Shared load/store definitions for the EX/MEM load/store unit: funct3 codes,
// access size encoding and helpers that decode funct3 into a size and a legality flag.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  // funct3[1:0] carries log2 of the access size for both loads and stores.
  function automatic size_e size_of(input logic [2:0] funct3);
    size_e sz;
    unique case (funct3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      2'b10:   sz = SZ_W;
      default: sz = SZ_D;
    endcase
    return sz;
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3, input logic is64);
    return (funct3 != 3'b111) && (is64 || ((funct3 != F3_LD) && (funct3 != F3_LWU)));
  endfunction

endpackage

// File: rtl/ex_mem_lsu_if.sv
// EX-to-MEM bundle: stage control, EX-side instruction fields and the registered
// MEM-side results. The master drives EX fields, the slave (the LSU) drives MEM fields.
interface ex_mem_lsu_if #(
  parameter int unsigned XLEN = 64
);
  logic            exmem_stall;
  logic            exmem_flush;
  logic            memread_ex;
  logic            memwrite_ex;
  logic            memtoreg_ex;
  logic            regwrite_ex;
  logic [2:0]      funct3_ex;
  logic [4:0]      dst_ex;
  logic [XLEN-1:0] aluresult_ex;
  logic [XLEN-1:0] storedata_ex;
  logic [XLEN-1:0] pcadd4_ex;

  logic            memtoreg_mem;
  logic            regwrite_mem;
  logic [4:0]      dst_mem;
  logic [XLEN-1:0] aluresult_mem;
  logic [XLEN-1:0] pcadd4_mem;
  logic [XLEN-1:0] dmemrd_mem;
  logic            misalign_mem;
  logic            access_fault_mem;

  modport master (
    output exmem_stall, exmem_flush, memread_ex, memwrite_ex, memtoreg_ex, regwrite_ex,
           funct3_ex, dst_ex, aluresult_ex, storedata_ex, pcadd4_ex,
    input  memtoreg_mem, regwrite_mem, dst_mem, aluresult_mem, pcadd4_mem, dmemrd_mem,
           misalign_mem, access_fault_mem
  );

  modport slave (
    input  exmem_stall, exmem_flush, memread_ex, memwrite_ex, memtoreg_ex, regwrite_ex,
           funct3_ex, dst_ex, aluresult_ex, storedata_ex, pcadd4_ex,
    output memtoreg_mem, regwrite_mem, dst_mem, aluresult_mem, pcadd4_mem, dmemrd_mem,
           misalign_mem, access_fault_mem
  );

endinterface

// File: rtl/ex_mem_lsu_dmem_bram.sv
// Byte-lane synchronous data RAM with per-lane write enables and a read enable that
// freezes the read register. Contents are not reset.
module dmem_bram #(
  parameter int unsigned BYTES = 8,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic               clk,
  input  logic               re,
  input  logic [BYTES-1:0]   be,
  input  logic [AW-1:0]      addr,
  input  logic [8*BYTES-1:0] wdata,
  output logic [8*BYTES-1:0] rdata
);

  (* ram_style = "block" *) logic [8*BYTES-1:0] mem [DEPTH];

  // Read-first: a same-cycle write is not visible on rdata until the next read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(BYTES); k++) begin
      if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ex_mem_lsu.sv
// EX/MEM pipeline register with the L1 data memory and load/store unit: fault
// detection, byte-enable store generation and load lane extraction/extension.
module ex_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DMEM_DEPTH = 512
) (
  input  logic        clk,
  input  logic        rstn,
  ex_mem_lsu_if.slave bus
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam int unsigned AW    = $clog2(DMEM_DEPTH);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DMEM_DEPTH * BYTES);

  logic [OFFW-1:0]  offset;
  logic [AW-1:0]    word_idx;
  size_e            size;
  logic [3:0]       nbytes;
  logic             legal, access, misalign, range_fault, fault, do_write;
  logic [BYTES-1:0] size_mask, byte_en;
  logic [XLEN-1:0]  wdata, rdata, shifted, ext;

  logic             memtoreg_q, regwrite_q, load_q, misalign_q, access_fault_q;
  logic [4:0]       dst_q;
  logic [XLEN-1:0]  aluresult_q, pcadd4_q;
  logic [OFFW-1:0]  off_q;
  logic [2:0]       funct3_q;

  always_comb begin
    offset      = bus.aluresult_ex[OFFW-1:0];
    word_idx    = bus.aluresult_ex[OFFW+AW-1:OFFW];
    size        = size_of(bus.funct3_ex);
    nbytes      = 4'd1 << size;
    legal       = f3_legal(bus.funct3_ex, XLEN == 64);
    access      = bus.memread_ex | bus.memwrite_ex;
    misalign    = access && legal && ((offset & OFFW'(nbytes - 4'd1)) != '0);
    range_fault = access && (!legal || (bus.aluresult_ex >= MEM_BYTES));
    fault       = misalign | range_fault;
    // rstn gating drops a store that coincides with reset assertion.
    do_write    = bus.memwrite_ex && !fault && !bus.exmem_stall && !bus.exmem_flush && rstn;
    for (int k = 0; k < int'(BYTES); k++) begin
      size_mask[k]    = k < int'(nbytes);
      wdata[8*k +: 8] = 8'(bus.storedata_ex >> {4'(k) & (nbytes - 4'd1), 3'b000});
    end
    byte_en = do_write ? (size_mask << offset) : '0;
  end

  dmem_bram #(
    .BYTES (BYTES),
    .DEPTH (DMEM_DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .re    (!bus.exmem_stall),
    .be    (byte_en),
    .addr  (word_idx),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memtoreg_q     <= 1'b0;
      regwrite_q     <= 1'b0;
      load_q         <= 1'b0;
      misalign_q     <= 1'b0;
      access_fault_q <= 1'b0;
      dst_q          <= '0;
      aluresult_q    <= '0;
      pcadd4_q       <= '0;
      off_q          <= '0;
      funct3_q       <= '0;
    end else if (!bus.exmem_stall) begin
      dst_q       <= bus.dst_ex;
      aluresult_q <= bus.aluresult_ex;
      pcadd4_q    <= bus.pcadd4_ex;
      off_q       <= offset;
      funct3_q    <= bus.funct3_ex;
      if (bus.exmem_flush) begin
        memtoreg_q     <= 1'b0;
        regwrite_q     <= 1'b0;
        load_q         <= 1'b0;
        misalign_q     <= 1'b0;
        access_fault_q <= 1'b0;
      end else begin
        memtoreg_q     <= bus.memtoreg_ex;
        regwrite_q     <= bus.regwrite_ex && !fault;
        load_q         <= bus.memread_ex && !bus.memwrite_ex && !fault;
        misalign_q     <= misalign;
        access_fault_q <= range_fault && !misalign;
      end
    end
  end

  always_comb begin
    shifted = rdata >> {off_q, 3'b000};
    case (funct3_q)
      F3_LB:   ext = XLEN'($signed(shifted[7:0]));
      F3_LH:   ext = XLEN'($signed(shifted[15:0]));
      F3_LW:   ext = XLEN'($signed(shifted[31:0]));
      F3_LBU:  ext = XLEN'(shifted[7:0]);
      F3_LHU:  ext = XLEN'(shifted[15:0]);
      F3_LWU:  ext = XLEN'(shifted[31:0]);
      default: ext = shifted;
    endcase
  end

  assign bus.memtoreg_mem     = memtoreg_q;
  assign bus.regwrite_mem     = regwrite_q;
  assign bus.dst_mem          = dst_q;
  assign bus.aluresult_mem    = aluresult_q;
  assign bus.pcadd4_mem       = pcadd4_q;
  assign bus.dmemrd_mem       = load_q ? ext : '0;
  assign bus.misalign_mem     = misalign_q;
  assign bus.access_fault_mem = access_fault_q;

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Bench for ex_mem_lsu: a 64-bit instance checked against a byte-array memory model
// under directed and random traffic, plus a small 32-bit instance.
module tb_ex_mem_lsu;

  localparam int unsigned DEPTH64 = 512;
  localparam int unsigned MEMB64  = DEPTH64 * 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ex_mem_lsu_if #(.XLEN(64)) b64 ();
  ex_mem_lsu_if #(.XLEN(32)) b32 ();

  ex_mem_lsu #(.XLEN(64), .DMEM_DEPTH(DEPTH64)) dut64 (.clk(clk), .rstn(rstn), .bus(b64));
  ex_mem_lsu #(.XLEN(32), .DMEM_DEPTH(64))      dut32 (.clk(clk), .rstn(rstn), .bus(b32));

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [MEMB64];
  logic        e_mtr, e_rw, e_mis, e_af;
  logic [4:0]  e_dst;
  logic [63:0] e_alu, e_pc, e_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".memtoreg"}, 64'(b64.memtoreg_mem), 64'(e_mtr));
    chk({tag, ".regwrite"}, 64'(b64.regwrite_mem), 64'(e_rw));
    chk({tag, ".dst"}, 64'(b64.dst_mem), 64'(e_dst));
    chk({tag, ".alu"}, b64.aluresult_mem, e_alu);
    chk({tag, ".pc4"}, b64.pcadd4_mem, e_pc);
    chk({tag, ".rd"}, b64.dmemrd_mem, e_rd);
    chk({tag, ".misalign"}, 64'(b64.misalign_mem), 64'(e_mis));
    chk({tag, ".afault"}, 64'(b64.access_fault_mem), 64'(e_af));
  endtask

  function automatic int nb(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      3'd3:       return 8;
      default:    return 0;
    endcase
  endfunction

  task automatic drive64(input bit rd, input bit wr, input bit mtr, input bit rw,
                         input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] data, input bit fl, input bit st);
    b64.exmem_stall  = st;
    b64.exmem_flush  = fl;
    b64.memread_ex   = rd;
    b64.memwrite_ex  = wr;
    b64.memtoreg_ex  = mtr;
    b64.regwrite_ex  = rw;
    b64.funct3_ex    = f3;
    b64.dst_ex       = 5'($urandom);
    b64.aluresult_ex = addr;
    b64.storedata_ex = data;
    b64.pcadd4_ex    = {$urandom, $urandom};
  endtask

  // Drive one instruction, predict from the byte model, clock, compare.
  task automatic op64(input bit rd, input bit wr, input bit mtr, input bit rw,
                      input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data,
                      input bit fl, input string tag);
    int n;
    bit legal, acc, mis, rng, fault;
    logic [63:0] v;
    drive64(rd, wr, mtr, rw, f3, addr, data, fl, 1'b0);
    n     = nb(f3);
    legal = (f3 != 3'd7);
    acc   = rd || wr;
    mis   = acc && legal && ((addr % 64'(n)) != 0);
    rng   = acc && (!legal || (addr >= 64'(MEMB64)));
    fault = mis || rng;
    v = '0;
    if (rd && !wr && !fault && !fl) begin
      for (int i = 0; i < n; i++) v = v | (64'(mem_m[addr + 64'(i)]) << (8 * i));
      if (f3 < 3'd3 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    end
    e_mtr = mtr && !fl;
    e_rw  = rw && !fault && !fl;
    e_dst = b64.dst_ex;
    e_alu = addr;
    e_pc  = b64.pcadd4_ex;
    e_rd  = v;
    e_mis = mis && !fl;
    e_af  = rng && !mis && !fl;
    @(posedge clk);
    #1;
    if (wr && !fault && !fl)
      for (int i = 0; i < n; i++) mem_m[addr + 64'(i)] = data[8*i +: 8];
    check_all(tag);
  endtask

  task automatic idle64();
    drive64(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic op32(input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] data);
    b32.exmem_stall  = 1'b0;
    b32.exmem_flush  = 1'b0;
    b32.memread_ex   = rd;
    b32.memwrite_ex  = wr;
    b32.memtoreg_ex  = rd;
    b32.regwrite_ex  = rd;
    b32.funct3_ex    = f3;
    b32.dst_ex       = 5'd7;
    b32.aluresult_ex = addr;
    b32.storedata_ex = data;
    b32.pcadd4_ex    = 32'h100;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit rd, wr, fl;
    logic [2:0]  f3;
    logic [63:0] addr;
    idle64();
    b32.exmem_stall = 1'b0; b32.exmem_flush = 1'b0; b32.memread_ex = 1'b0;
    b32.memwrite_ex = 1'b0; b32.memtoreg_ex = 1'b0; b32.regwrite_ex = 1'b0;
    b32.funct3_ex = 3'd0; b32.dst_ex = 5'd0; b32.aluresult_ex = '0;
    b32.storedata_ex = '0; b32.pcadd4_ex = '0;
    {e_mtr, e_rw, e_mis, e_af} = '0; e_dst = '0; e_alu = '0; e_pc = '0; e_rd = '0;
    for (int i = 0; i < int'(MEMB64); i++) mem_m[i] = 8'h00;

    #12;
    check_all("reset");
    chk("reset32.alu", 64'(b32.aluresult_mem), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int w = 0; w < int'(DEPTH64); w++)
      op64(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'(w * 8), 64'd0, 1'b0, "clear");

    // Directed cases.
    op64(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'h10, 64'h8877665544332211, 1'b0, "t1_sd");
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 64'h17, 64'd0, 1'b0, "t1_lb");
    chk("t1_lb_const", b64.dmemrd_mem, 64'hFFFF_FFFF_FFFF_FF88);
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 64'h17, 64'd0, 1'b0, "t1_lbu");
    chk("t1_lbu_const", b64.dmemrd_mem, 64'h88);
    op64(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 64'h22, 64'hBEEF, 1'b0, "t2_sh");
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h20, 64'd0, 1'b0, "t2_ld");
    chk("t2_ld_const", b64.dmemrd_mem, 64'h0000_0000_BEEF_0000);
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 64'h1A, 64'd0, 1'b0, "t3_lw_mis");
    chk("t3_mis_const", 64'(b64.misalign_mem), 64'd1);
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h18, 64'd0, 1'b0, "t3_ld");
    chk("t3_ld_const", b64.dmemrd_mem, 64'd0);
    op64(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'h0, 64'h1122334455667788, 1'b0, "t4_sd0");
    op64(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 64'(MEMB64), 64'hDEAD, 1'b0, "t4_sw_oor");
    chk("t4_af_const", 64'(b64.access_fault_mem), 64'd1);
    op64(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'h40, 64'd0, 1'b0, "t4_nop");
    chk("t4_af_clear", 64'(b64.access_fault_mem), 64'd0);
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h0, 64'd0, 1'b0, "t4_ld0");
    chk("t4_ld0_const", b64.dmemrd_mem, 64'h1122334455667788);
    op64(1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 64'h30, 64'hCAFE, 1'b0, "rd_wr_both");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom);
      wr = ($urandom % 3) == 0;
      f3 = 3'($urandom);
      fl = ($urandom % 10) == 0;
      n  = nb(f3);
      if (($urandom % 20) == 0) addr = 64'(MEMB64) + 64'($urandom % 64);
      else if (($urandom % 40) == 0) addr = {$urandom, $urandom};
      else addr = 64'($urandom_range(0, MEMB64 - 1));
      if (n > 0 && ($urandom % 4) != 0) addr = addr & ~64'(n - 1);
      op64(rd, wr, 1'($urandom), 1'($urandom), f3, addr, {$urandom, $urandom}, fl, "rand");
    end

    // 32-bit build.
    idle64();
    op32(1'b1, 1'b0, 3'd3, 32'h0, 32'd0);
    chk("x32_ld_af", 64'(b32.access_fault_mem), 64'd1);
    chk("x32_ld_rw", 64'(b32.regwrite_mem), 64'd0);
    op32(1'b0, 1'b0, 3'd0, 32'h4, 32'd0);
    chk("x32_af_clear", 64'(b32.access_fault_mem), 64'd0);
    op32(1'b0, 1'b1, 3'd2, 32'h8, 32'hDEADBEEF);
    op32(1'b1, 1'b0, 3'd4, 32'hB, 32'd0);
    chk("x32_lbu", 64'(b32.dmemrd_mem), 64'hDE);
    op32(1'b1, 1'b0, 3'd6, 32'h8, 32'd0);
    chk("x32_lwu_af", 64'(b32.access_fault_mem), 64'd1);
    op32(1'b1, 1'b0, 3'd2, 32'h2, 32'd0);
    chk("x32_lw_mis", 64'(b32.misalign_mem), 64'd1);
    op32(1'b0, 1'b1, 3'd2, 32'd256, 32'h1);
    chk("x32_sw_oor", 64'(b32.access_fault_mem), 64'd1);
    op32(1'b1, 1'b0, 3'd1, 32'hA, 32'd0);
    chk("x32_lh", 64'(b32.dmemrd_mem), 64'hFFFFDEAD);

    // Stall (with flush overlap) holds everything and blocks the store.
    op64(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'h100, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, "st_base");
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h100, 64'd0, 1'b0, "ld_pre_stall");
    for (int c = 0; c < 3; c++) begin
      drive64(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 64'h100, 64'h1234, c == 1, 1'b1);
      @(posedge clk); #1;
      check_all("stall_hold");
    end
    op64(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 64'h100, 64'h1234, 1'b1, "flush_sd");
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h100, 64'd0, 1'b0, "no_write_stall");
    op64(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'h100, 64'h1234, 1'b0, "sd_release");
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h100, 64'd0, 1'b0, "ld_release");

    // Asynchronous reset mid-cycle with a store pending.
    drive64(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    {e_mtr, e_rw, e_mis, e_af} = '0; e_dst = '0; e_alu = '0; e_pc = '0; e_rd = '0;
    check_all("async_rst");
    chk("async_rst32.rd", 64'(b32.dmemrd_mem), 64'd0);
    chk("async_rst32.rw", 64'(b32.regwrite_mem), 64'd0);
    @(posedge clk); #1;
    check_all("rst_hold");
    rstn = 1'b1;
    op64(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h100, 64'd0, 1'b0, "rst_store_discard");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
